// File: rtl/char_decoder.sv
// Morse character keyer: accepts one packed character at a time and plays its
// dots/dashes on key, with unit-accurate gaps, word spaces, ETX and error pulses.
module char_decoder #(
   parameter int UNIT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] character_data,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       key,
   output logic       etx_out,
   output logic       error
);

   typedef enum logic [1:0] {IDLE, MARK, GAP, TAIL} state_t;

   localparam logic [15:0] LAST_CYC = 16'(UNIT_CYCLES - 1);

   state_t      state_q;
   logic [15:0] cyc_q;
   logic [2:0]  units_q;
   logic [2:0]  idx_q;
   logic [4:0]  sym_q;
   logic        key_q;
   logic        etx_q;
   logic        err_q;

   logic [2:0]  cnt;
   logic [4:0]  sym;
   logic        unit_end;

   assign cnt      = character_data[7:5];
   assign sym      = character_data[4:0];
   assign unit_end = (cyc_q == LAST_CYC);

   // units_q holds the units still to run after the current one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         units_q <= '0;
         idx_q   <= '0;
         sym_q   <= '0;
         key_q   <= 1'b0;
         etx_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         etx_q <= 1'b0;
         err_q <= 1'b0;
         if (state_q == IDLE) begin
            if (char_valid) begin
               cyc_q <= '0;
               if (cnt >= 3'd1 && cnt <= 3'd5) begin
                  state_q <= MARK;
                  key_q   <= 1'b1;
                  idx_q   <= cnt - 3'd1;
                  sym_q   <= sym;
                  units_q <= sym[cnt - 3'd1] ? 3'd2 : 3'd0;
               end else if (character_data == 8'hC0) begin
                  state_q <= TAIL;
                  units_q <= 3'd6;
               end else if (character_data == 8'hE0) begin
                  etx_q <= 1'b1;
               end else begin
                  err_q <= 1'b1;
               end
            end
         end else if (!unit_end) begin
            cyc_q <= cyc_q + 16'd1;
         end else begin
            cyc_q <= '0;
            if (units_q != 3'd0) begin
               units_q <= units_q - 3'd1;
            end else begin
               case (state_q)
                  MARK: begin
                     key_q <= 1'b0;
                     if (idx_q != 3'd0) begin
                        state_q <= GAP;
                        idx_q   <= idx_q - 3'd1;
                        units_q <= 3'd0;
                     end else begin
                        state_q <= TAIL;
                        units_q <= 3'd2;
                     end
                  end
                  GAP: begin
                     state_q <= MARK;
                     key_q   <= 1'b1;
                     units_q <= sym_q[idx_q] ? 3'd2 : 3'd0;
                  end
                  default: begin
                     state_q <= IDLE;
                     key_q   <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign char_ready = (state_q == IDLE);
   assign key        = key_q;
   assign etx_out    = etx_q;
   assign error      = err_q;

endmodule
